// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard input path.
package ps2_pkg;

    // Scan-code prefix tracking states for the set-2 decoder.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } kbd_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Returns {hit, ascii}. Only letters, digits and space are meaningful to the game.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
        logic [8:0] res;
        res = 9'h000;
        case (code)
            8'h1C: res = {1'b1, 8'h41}; // A
            8'h32: res = {1'b1, 8'h42}; // B
            8'h21: res = {1'b1, 8'h43}; // C
            8'h23: res = {1'b1, 8'h44}; // D
            8'h24: res = {1'b1, 8'h45}; // E
            8'h2B: res = {1'b1, 8'h46}; // F
            8'h34: res = {1'b1, 8'h47}; // G
            8'h33: res = {1'b1, 8'h48}; // H
            8'h43: res = {1'b1, 8'h49}; // I
            8'h3B: res = {1'b1, 8'h4A}; // J
            8'h42: res = {1'b1, 8'h4B}; // K
            8'h4B: res = {1'b1, 8'h4C}; // L
            8'h3A: res = {1'b1, 8'h4D}; // M
            8'h31: res = {1'b1, 8'h4E}; // N
            8'h44: res = {1'b1, 8'h4F}; // O
            8'h4D: res = {1'b1, 8'h50}; // P
            8'h15: res = {1'b1, 8'h51}; // Q
            8'h2D: res = {1'b1, 8'h52}; // R
            8'h1B: res = {1'b1, 8'h53}; // S
            8'h2C: res = {1'b1, 8'h54}; // T
            8'h3C: res = {1'b1, 8'h55}; // U
            8'h2A: res = {1'b1, 8'h56}; // V
            8'h1D: res = {1'b1, 8'h57}; // W
            8'h22: res = {1'b1, 8'h58}; // X
            8'h35: res = {1'b1, 8'h59}; // Y
            8'h1A: res = {1'b1, 8'h5A}; // Z
            8'h45: res = {1'b1, 8'h30}; // 0
            8'h16: res = {1'b1, 8'h31}; // 1
            8'h1E: res = {1'b1, 8'h32}; // 2
            8'h26: res = {1'b1, 8'h33}; // 3
            8'h25: res = {1'b1, 8'h34}; // 4
            8'h2E: res = {1'b1, 8'h35}; // 5
            8'h36: res = {1'b1, 8'h36}; // 6
            8'h3D: res = {1'b1, 8'h37}; // 7
            8'h3E: res = {1'b1, 8'h38}; // 8
            8'h46: res = {1'b1, 8'h39}; // 9
            8'h29: res = {1'b1, 8'h20}; // space
            default: res = 9'h000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in 11-bit frames on
// falling PS/2 clock edges, validates start/parity/stop and abandons stalled frames.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    sync_clk_reg;
    logic [1:0]    sync_dat_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          code_valid_reg;
    logic [7:0]    code_reg;
    logic          frame_err_reg;

    logic          fall;
    logic [10:0]   frame;
    logic          frame_ok;

    // Oldest two clock samples show a 1 -> 0 transition; data is aligned to sample [1].
    assign fall     = (sync_clk_reg[2:1] == 2'b10);
    // Full frame as it stands on the stop-bit edge: bit 0 is start, bit 10 is stop.
    assign frame    = {sync_dat_reg[1], shift_reg};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    // Synchronisers for the asynchronous PS/2 lines; reset to idle-high so release is quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_clk_reg <= 3'b111;
            sync_dat_reg <= 2'b11;
        end else begin
            sync_clk_reg <= {sync_clk_reg[1:0], ps2_clk};
            sync_dat_reg <= {sync_dat_reg[0], ps2_dat};
        end
    end

    // Bit shifter, frame check and stall timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 10'd0;
            tmo_cnt_reg    <= '0;
            code_valid_reg <= 1'b0;
            code_reg       <= 8'd0;
            frame_err_reg  <= 1'b0;
        end else begin
            code_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (fall) begin
                tmo_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= 4'd0;
                    if (frame_ok) begin
                        code_valid_reg <= 1'b1;
                        code_reg       <= frame[8:1];
                    end else begin
                        frame_err_reg  <= 1'b1;
                    end
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    shift_reg   <= {sync_dat_reg[1], shift_reg[9:1]};
                end
            end else if (bit_cnt_reg != 4'd0) begin
                if (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_cnt_reg   <= '0;
                    bit_cnt_reg   <= 4'd0;
                    frame_err_reg <= 1'b1;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                end
            end else begin
                tmo_cnt_reg <= '0;
            end
        end
    end

    assign code_valid = code_valid_reg;
    assign code       = code_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// Top of the keyboard input stage: frame receiver, set-2 make/break decoder with
// repeat suppression, and a keypress FIFO with a registered head.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic [7:0] err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic       code_valid;
    logic [7:0] code;
    logic       frame_err;
    logic [8:0] lookup;

    kbd_state_t state_reg;
    logic [7:0] held_code_reg;
    logic       push_reg;
    logic [7:0] push_data_reg;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] wr_ptr_next, rd_ptr_next;
    logic        out_valid_reg;
    logic [7:0]  out_data_reg;
    logic        overflow_reg;
    logic [7:0]  err_cnt_reg;
    logic        full, do_pop, do_push, bypass;

    ps2_frame_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .code_valid(code_valid),
        .code      (code),
        .frame_err (frame_err)
    );

    assign lookup = scan_to_ascii(code);

    // Prefix-tracking decoder; a make code only produces a keypress when it differs
    // from the key currently held, so typematic repeats are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            held_code_reg <= 8'd0;
            push_reg      <= 1'b0;
            push_data_reg <= 8'd0;
        end else begin
            push_reg <= 1'b0;
            if (code_valid) begin
                case (state_reg)
                    IDLE: begin
                        if (code == SC_BREAK) begin
                            state_reg <= BREAK;
                        end else if (code == SC_EXT) begin
                            state_reg <= EXT;
                        end else if (lookup[8] && (code != held_code_reg)) begin
                            held_code_reg <= code;
                            push_reg      <= 1'b1;
                            push_data_reg <= lookup[7:0];
                        end
                    end
                    BREAK: begin
                        state_reg <= IDLE;
                        if (code == held_code_reg) held_code_reg <= 8'd0;
                    end
                    EXT: begin
                        state_reg <= (code == SC_BREAK) ? EXT_BREAK : IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign full        = ((wr_ptr_reg - rd_ptr_reg) == (AW+1)'(FIFO_DEPTH));
    assign do_pop      = out_valid_reg & out_ready;
    assign do_push     = push_reg & (~full | do_pop);
    assign wr_ptr_next = do_push ? wr_ptr_reg + (AW+1)'(1) : wr_ptr_reg;
    assign rd_ptr_next = do_pop  ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;
    // The incoming entry becomes the head when it lands exactly where the read pointer goes next.
    assign bypass      = do_push & (wr_ptr_reg == rd_ptr_next);

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data_reg;
    end

    // Pointers, registered head, and the sticky status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'd0;
            overflow_reg  <= 1'b0;
            err_cnt_reg   <= 8'd0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            out_valid_reg <= (wr_ptr_next != rd_ptr_next);
            if (wr_ptr_next != rd_ptr_next)
                out_data_reg <= bypass ? push_data_reg : mem[rd_ptr_next[AW-1:0]];
            if (push_reg && full && !do_pop)
                overflow_reg <= 1'b1;
            if (frame_err && (err_cnt_reg != 8'hFF))
                err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign overflow  = overflow_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames, keeps a spec-level model of the
// expected keypress stream and error count, and checks every pop against it.
module tb_ps2_key_decoder;
    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    bit           m_ovf;
    int           m_err;
    bit           m_brk, m_ext;
    byte unsigned m_held;
    int           ready_mode;
    bit           prev_hold;
    logic [7:0]   prev_data;

    byte unsigned keys[37] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45,
                               8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                               8'h29};
    string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";

    ps2_key_decoder #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int ref_ascii(byte unsigned c);
        for (int i = 0; i < 37; i++)
            if (keys[i] == c) return int'(chars[i]);
        return -1;
    endfunction

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic chk_got(string name, string req);
        string s;
        s = "";
        foreach (got_q[i]) s = $sformatf("%s%c", s, got_q[i]);
        total++;
        if (s != req) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, s, req);
        end
        got_q.delete();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 0; m_err = 0; m_brk = 0; m_ext = 0; m_held = 0;
    endtask

    // Model of the key semantics: prefixes F0/E0 modify the next code; make codes of
    // mapped keys are reported once until released.
    task automatic model_code(byte unsigned c);
        int a;
        if (m_ext) begin
            if (m_brk) begin m_ext = 0; m_brk = 0; end
            else if (c == 8'hF0) m_brk = 1;
            else m_ext = 0;
        end else if (m_brk) begin
            m_brk = 0;
            if (c == m_held) m_held = 0;
        end else if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) m_ext = 1;
        else begin
            a = ref_ascii(c);
            if (a >= 0 && c != m_held) begin
                m_held = c;
                if (exp_q.size() >= DEPTH) m_ovf = 1;
                else exp_q.push_back(byte'(a));
            end
        end
    endtask

    task automatic model_err_inc();
        if (m_err < 255) m_err++;
    endtask

    task automatic send_bits(logic [10:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    // fault: 0 clean, 1 bad parity, 2 bad stop, 3 bad start
    task automatic send_frame(byte unsigned c, int fault);
        logic [10:0] bits;
        logic        par;
        par  = ~(^c);
        bits = {1'b1, par, c, 1'b0};
        if (fault == 1) bits[9]  = ~par;
        if (fault == 2) bits[10] = 1'b0;
        if (fault == 3) bits[0]  = 1'b1;
        if (fault == 0) model_code(c);
        else model_err_inc();
        send_bits(bits, 11);
        repeat (20) @(posedge clk);
        $display("frame %02h fault=%0d", c, fault);
    endtask

    task automatic settle(string name);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk({name, "_err_cnt"}, int'(err_cnt), m_err);
        chk({name, "_overflow"}, int'(overflow), int'(m_ovf));
    endtask

    task automatic drain(string name);
        int n;
        ready_mode = 1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_drain_left"}, exp_q.size(), 0);
        chk({name, "_drain_valid"}, int'(out_valid), 0);
    endtask

    task automatic check_reset(string name);
        @(negedge clk);
        chk({name, "_out_valid"}, int'(out_valid), 0);
        chk({name, "_out_data"}, int'(out_data), 0);
        chk({name, "_overflow"}, int'(overflow), 0);
        chk({name, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    // Consumer handshake driver.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Every pop is checked against the model; a held head must not change.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    bad++;
                    $display("FAIL head_stable: got v=%0b d=%02h want v=1 d=%02h",
                             out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected: got %02h want nothing", out_data);
                end else begin
                    byte unsigned e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL pop_data: got %02h want %02h", out_data, e);
                    end
                end
                got_q.push_back(out_data);
                $display("pop %02h", out_data);
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned c;
        int           r, f;
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; ready_mode = 0;
        model_reset();
        repeat (5) @(posedge clk);
        rst = 1'b0;
        check_reset("reset");

        // Single key.
        ready_mode = 1;
        chk("model_1C", ref_ascii(8'h1C), 8'h41);
        send_frame(8'h1C, 0);
        settle("single");
        chk_got("single_out", "A");
        chk("single_err_lit", int'(err_cnt), 0);

        // Release the held key, then repeat suppression and re-press after break.
        send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        got_q.delete();
        send_frame(8'h1C, 0); send_frame(8'h1C, 0); send_frame(8'h1C, 0);
        send_frame(8'hF0, 0); send_frame(8'h1C, 0); send_frame(8'h1C, 0);
        settle("repeat");
        chk_got("repeat_out", "AA");

        // Bad parity, then bad stop bit.
        send_frame(8'h45, 1);
        settle("parity");
        chk("parity_err_lit", int'(err_cnt), 1);
        send_frame(8'h45, 2);
        settle("stop");
        chk("stop_err_lit", int'(err_cnt), 2);
        chk_got("bad_frames_out", "");

        // Extended make/break ignored, then space.
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        send_frame(8'h29, 0);
        settle("ext");
        chk_got("ext_out", " ");

        // Fill past capacity with the consumer stalled.
        ready_mode = 0;
        send_frame(8'h15, 0); send_frame(8'h1D, 0); send_frame(8'h24, 0);
        send_frame(8'h2D, 0); send_frame(8'h2C, 0); send_frame(8'h35, 0);
        send_frame(8'h3C, 0); send_frame(8'h43, 0); send_frame(8'h44, 0);
        settle("ovf");
        chk("ovf_lit", int'(overflow), 1);
        chk("ovf_model_depth", exp_q.size(), DEPTH);
        drain("ovf");
        chk_got("ovf_out", "QWERTYUI");

        // Stalled partial frame times out.
        model_err_inc();
        send_bits(11'b000_0101_1000, 4);
        repeat (TMO + 10) @(posedge clk);
        settle("timeout");
        chk("timeout_err_lit", int'(err_cnt), 3);
        send_frame(8'h16, 0);
        settle("after_tmo");
        chk_got("after_tmo_out", "1");

        // Reset in the middle of a frame.
        send_bits(11'b000_0111_0000, 5);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        model_reset();
        rst = 1'b0;
        check_reset("midrst");
        got_q.delete();
        send_frame(8'h1C, 0);
        settle("after_rst");
        chk_got("after_rst_out", "A");

        // Randomised traffic with a jittery consumer.
        ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       c = keys[$urandom_range(0, 36)];
            else if (r == 6) c = 8'hF0;
            else if (r == 7) c = 8'hE0;
            else if (r == 8) c = 8'($urandom);
            else             c = (m_held != 0) ? m_held : keys[$urandom_range(0, 36)];
            f = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            send_frame(c, f);
        end
        drain("random");
        settle("random");
        got_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
